// File: rtl/ctrl_pkt_tx.sv
// Control-path packet transmitter: one table-write request becomes a header beat
// followed by ceil(ENTRY_WIDTH/256) payload beats on the c_m_axis control stream.
module ctrl_pkt_tx #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned ENTRY_WIDTH          = 625,
    parameter logic [15:0] CTRL_TAG             = 16'hf1f2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [7:0]                           req_module_id,
    input  logic [3:0]                           req_flags,
    input  logic [3:0]                           req_table_type,
    input  logic [7:0]                           req_index,
    input  logic [ENTRY_WIDTH-1:0]               req_entry,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    input  logic                                 c_m_axis_tready,
    output logic                                 c_m_axis_tlast,
    output logic [31:0]                          tx_pkt_cnt
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned NB = (ENTRY_WIDTH + DW - 1) / DW;
    localparam int unsigned PW = NB * DW;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    if (C_S_AXIS_DATA_WIDTH != 256) begin : g_bad_dw
        $error("ctrl_pkt_tx: only a 256-bit stream is supported");
    end
    if (ENTRY_WIDTH < 1 || ENTRY_WIDTH > 2048) begin : g_bad_ew
        $error("ctrl_pkt_tx: ENTRY_WIDTH must be 1..2048");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_beat;
    logic [PW-1:0]   r_entry;
    logic [DW-1:0]   r_tdata;
    logic [DW/8-1:0] r_tkeep;
    logic            r_tvalid;
    logic            r_tlast;
    logic            r_req_ready;
    logic [31:0]     r_pkt_cnt;

    logic [PW-1:0]   w_entry_pad;
    logic [PW-1:0]   w_entry_shift;
    logic [DW-1:0]   w_hdr;
    logic [BW-1:0]   w_beat_inc;

    always_comb begin
        w_entry_pad                   = '0;
        w_entry_pad[ENTRY_WIDTH-1:0]  = req_entry;
    end

    always_comb begin
        w_hdr            = '0;
        w_hdr[79:64]     = CTRL_TAG;
        w_hdr[119:112]   = req_module_id;
        w_hdr[123:120]   = req_flags;
        w_hdr[127:124]   = req_table_type;
        w_hdr[135:128]   = req_index;
    end

    // Payload is consumed from the bottom of a shift register, so the next beat is always [DW-1:0].
    if (NB > 1) begin : g_multi
        assign w_entry_shift = {{DW{1'b0}}, r_entry[PW-1:DW]};
    end else begin : g_single
        assign w_entry_shift = '0;
    end

    assign w_beat_inc = r_beat + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_entry     <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_req_ready <= 1'b0;
            r_pkt_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_entry     <= w_entry_pad;
                        r_tdata     <= w_hdr;
                        r_tkeep     <= '1;
                        r_tvalid    <= 1'b1;
                        r_tlast     <= 1'b0;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (c_m_axis_tready) begin
                        r_tdata <= r_entry[DW-1:0];
                        r_entry <= w_entry_shift;
                        r_beat  <= '0;
                        r_tlast <= (NB == 1);
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (c_m_axis_tready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_tdata     <= '0;
                            r_tkeep     <= '0;
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_tdata <= r_entry[DW-1:0];
                            r_entry <= w_entry_shift;
                            r_beat  <= w_beat_inc;
                            r_tlast <= (w_beat_inc == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tvalid    <= 1'b0;
                    r_tlast     <= 1'b0;
                    r_tkeep     <= '0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign c_m_axis_tdata  = r_tdata;
    assign c_m_axis_tuser  = '0;
    assign c_m_axis_tkeep  = r_tkeep;
    assign c_m_axis_tvalid = r_tvalid;
    assign c_m_axis_tlast  = r_tlast;
    assign tx_pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_ctrl_pkt_tx.sv
// Bench for ctrl_pkt_tx: table-driven requests with a beat scoreboard on the default
// build, plus hand sequences for back-to-back, mid-packet reset and a 256-bit-entry build.
`timescale 1ns/1ps
module tb_ctrl_pkt_tx;

    localparam int unsigned EW  = 625;
    localparam int unsigned EWB = 256;

    typedef struct {
        logic [255:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        logic [7:0]    mid;
        logic [3:0]    fl;
        logic [3:0]    tt;
        logic [7:0]    idx;
        logic [EW-1:0] ent;
        bit            stall;
        logic [255:0]  hdr;
        logic [31:0]   cnt;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid, req_ready;
    logic [7:0]     req_module_id, req_index;
    logic [3:0]     req_flags, req_table_type;
    logic [EW-1:0]  req_entry;
    logic [255:0]   c_m_axis_tdata;
    logic [127:0]   c_m_axis_tuser;
    logic [31:0]    c_m_axis_tkeep;
    logic           c_m_axis_tvalid, c_m_axis_tready, c_m_axis_tlast;
    logic [31:0]    tx_pkt_cnt;

    logic           b_req_valid, b_req_ready;
    logic [7:0]     b_req_module_id, b_req_index;
    logic [3:0]     b_req_flags, b_req_table_type;
    logic [EWB-1:0] b_req_entry;
    logic [255:0]   b_tdata;
    logic [127:0]   b_tuser;
    logic [31:0]    b_tkeep;
    logic           b_tvalid, b_tlast;
    logic           b_tready = 1'b1;
    logic [31:0]    b_cnt;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    beat_t       exp_q[$];
    int unsigned rise_q[$];
    bit          rdy_mode = 1'b0;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec_t        tbl [4];

    ctrl_pkt_tx #(.ENTRY_WIDTH(EW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_module_id(req_module_id), .req_flags(req_flags),
        .req_table_type(req_table_type), .req_index(req_index), .req_entry(req_entry),
        .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
        .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tready(c_m_axis_tready), .c_m_axis_tlast(c_m_axis_tlast),
        .tx_pkt_cnt(tx_pkt_cnt)
    );

    ctrl_pkt_tx #(.ENTRY_WIDTH(EWB)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_module_id(b_req_module_id), .req_flags(b_req_flags),
        .req_table_type(b_req_table_type), .req_index(b_req_index), .req_entry(b_req_entry),
        .c_m_axis_tdata(b_tdata), .c_m_axis_tuser(b_tuser),
        .c_m_axis_tkeep(b_tkeep), .c_m_axis_tvalid(b_tvalid),
        .c_m_axis_tready(b_tready), .c_m_axis_tlast(b_tlast),
        .tx_pkt_cnt(b_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string exp);
        checks++;
        errors++;
        $display("FAIL %s: got=%s required=%s", name, got, exp);
    endtask

    function automatic logic [EW-1:0] rand_ent();
        logic [639:0] t;
        for (int w = 0; w < 20; w++) t[w*32 +: 32] = $urandom;
        return t[EW-1:0];
    endfunction

    // tready: held high, or cycled through the 1,0,0,1,0,1 backpressure pattern
    initial begin
        int pidx = 0;
        c_m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                c_m_axis_tready = pat[pidx];
                pidx = (pidx + 1) % 6;
            end else begin
                c_m_axis_tready = 1'b1;
            end
        end
    end

    // Beat monitor: pops the scoreboard on each handshake and checks hold-under-stall
    logic [255:0] prev_data;
    logic         prev_last;
    bit           prev_stall = 1'b0;
    bit           prev_tv = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_tv    = 1'b0;
        end else begin
            if (c_m_axis_tvalid) begin
                if (!prev_tv) rise_q.push_back(cyc);
                chk32("tkeep_on", c_m_axis_tkeep, 32'hffffffff);
                chk32("busy_ready", 32'(req_ready), 32'd0);
                chk("tuser", 256'(c_m_axis_tuser), '0);
                if (prev_stall) begin
                    chk("hold_data", c_m_axis_tdata, prev_data);
                    chk32("hold_last", 32'(c_m_axis_tlast), 32'(prev_last));
                end
                if (c_m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        fail("extra_beat", "beat", "none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", c_m_axis_tdata, e.d);
                        chk32("beat_last", 32'(c_m_axis_tlast), 32'(e.l));
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = c_m_axis_tdata;
                    prev_last  = c_m_axis_tlast;
                end
            end else begin
                if (prev_stall) fail("stalled_beat_dropped", "tvalid=0", "tvalid=1");
                chk32("tkeep_off", c_m_axis_tkeep, 32'd0);
                chk32("tlast_off", 32'(c_m_axis_tlast), 32'd0);
                prev_stall = 1'b0;
            end
            prev_tv = c_m_axis_tvalid;
        end
    end

    task automatic drive_req(input logic [7:0] mid, input logic [3:0] fl, input logic [3:0] tt,
                             input logic [7:0] idx, input logic [EW-1:0] ent, input logic [255:0] hdr);
        logic [767:0] pad;
        beat_t b;
        req_module_id  = mid;
        req_flags      = fl;
        req_table_type = tt;
        req_index      = idx;
        req_entry      = ent;
        req_valid      = 1'b1;
        pad = '0;
        pad[EW-1:0] = ent;
        b.d = hdr;
        b.l = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < 3; k++) begin
            b.d = pad[k*256 +: 256];
            b.l = (k == 2);
            exp_q.push_back(b);
        end
    endtask

    // Returns #1 after the edge that accepted the request
    task automatic wait_accept(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (req_ready !== 1'b1) fail(name, "req_ready stuck 0", "accept");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail(name, "beats outstanding", "packet complete");
            exp_q.delete();
        end
        chk32("ready_return", 32'(req_ready), 32'd1);
        chk32("idle_tvalid", 32'(c_m_axis_tvalid), 32'd0);
    endtask

    task automatic scramble();
        req_module_id  = 8'($urandom);
        req_flags      = 4'($urandom);
        req_table_type = 4'($urandom);
        req_index      = 8'($urandom);
        req_entry      = rand_ent();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [EW-1:0]  e3;
        logic [EWB-1:0] eee;
        int n;

        tbl[0].mid = 8'h01; tbl[0].fl = 4'h0; tbl[0].tt = 4'h1; tbl[0].idx = 8'h00;
        tbl[0].ent = '1;    tbl[0].stall = 1'b0; tbl[0].cnt = 32'd1;
        tbl[0].hdr = {128'h0, 128'h10010000_0000f1f2_00000000_00000000};
        tbl[1] = tbl[0];
        tbl[1].stall = 1'b1; tbl[1].cnt = 32'd2;
        tbl[2].mid = 8'h5a; tbl[2].fl = 4'h3; tbl[2].tt = 4'h7; tbl[2].idx = 8'hc3;
        tbl[2].ent = EW'({20{32'hdeadbeef}}); tbl[2].stall = 1'b0; tbl[2].cnt = 32'd3;
        tbl[2].hdr = {128'hc3, 128'h735a0000_0000f1f2_00000000_00000000};
        e3 = '0;
        e3[EW-1] = 1'b1;
        e3[0]    = 1'b1;
        tbl[3].mid = 8'hff; tbl[3].fl = 4'hf; tbl[3].tt = 4'hf; tbl[3].idx = 8'hff;
        tbl[3].ent = e3;    tbl[3].stall = 1'b1; tbl[3].cnt = 32'd4;
        tbl[3].hdr = {128'hff, 128'hffff0000_0000f1f2_00000000_00000000};

        rst_n = 1'b0;
        req_valid = 1'b0; req_module_id = '0; req_flags = '0; req_table_type = '0;
        req_index = '0; req_entry = '0;
        b_req_valid = 1'b0; b_req_module_id = '0; b_req_flags = '0; b_req_table_type = '0;
        b_req_index = '0; b_req_entry = '0;
        repeat (2) @(posedge clk);
        #1;
        chk32("rst_tvalid", 32'(c_m_axis_tvalid), 32'd0);
        chk32("rst_tlast", 32'(c_m_axis_tlast), 32'd0);
        chk("rst_tdata", c_m_axis_tdata, '0);
        chk32("rst_tkeep", c_m_axis_tkeep, 32'd0);
        chk32("rst_ready", 32'(req_ready), 32'd0);
        chk32("rst_cnt", tx_pkt_cnt, 32'd0);
        chk32("rst_b_tvalid", 32'(b_tvalid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rdy_mode = tbl[i].stall;
            drive_req(tbl[i].mid, tbl[i].fl, tbl[i].tt, tbl[i].idx, tbl[i].ent, tbl[i].hdr);
            wait_accept("accept_timeout");
            req_valid = 1'b0;
            scramble();
            chk32("hdr_latency", 32'(c_m_axis_tvalid), 32'd1);
            chk32("hdr_tlast", 32'(c_m_axis_tlast), 32'd0);
            wait_done("pkt_timeout");
            chk32("pkt_cnt", tx_pkt_cnt, tbl[i].cnt);
        end

        // back-to-back with req_valid held high
        rdy_mode = 1'b0;
        @(posedge clk);
        #1;
        rise_q.delete();
        drive_req(8'h01, 4'h0, 4'h1, 8'h00, rand_ent(), tbl[0].hdr);
        wait_accept("b2b_accept1");
        drive_req(8'h01, 4'h0, 4'h2, 8'h02, rand_ent(),
                  {128'h02, 128'h20010000_0000f1f2_00000000_00000000});
        wait_accept("b2b_accept2");
        req_valid = 1'b0;
        wait_done("b2b_timeout");
        chk32("b2b_headers", rise_q.size(), 32'd2);
        if (rise_q.size() == 2) chk32("b2b_spacing", rise_q[1] - rise_q[0], 32'd5);
        chk32("b2b_cnt", tx_pkt_cnt, 32'd6);

        // reset asserted while payload beat 1 is on the bus
        drive_req(8'h01, 4'h0, 4'h1, 8'h00, rand_ent(), tbl[0].hdr);
        wait_accept("rst_accept");
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk32("mid_rst_tvalid", 32'(c_m_axis_tvalid), 32'd0);
        chk32("mid_rst_tlast", 32'(c_m_axis_tlast), 32'd0);
        chk("mid_rst_tdata", c_m_axis_tdata, '0);
        chk32("mid_rst_tkeep", c_m_axis_tkeep, 32'd0);
        chk32("mid_rst_ready", 32'(req_ready), 32'd0);
        chk32("mid_rst_cnt", tx_pkt_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk32("rst_hold_tlast", 32'(c_m_axis_tlast), 32'd0);
            chk32("rst_hold_tvalid", 32'(c_m_axis_tvalid), 32'd0);
        end
        rst_n = 1'b1;
        drive_req(tbl[0].mid, tbl[0].fl, tbl[0].tt, tbl[0].idx, tbl[0].ent, tbl[0].hdr);
        wait_accept("post_rst_accept");
        req_valid = 1'b0;
        wait_done("post_rst_timeout");
        chk32("post_rst_cnt", tx_pkt_cnt, 32'd1);

        // fields change in flight and a second request is raised during DATA
        rdy_mode = 1'b1;
        drive_req(tbl[2].mid, tbl[2].fl, tbl[2].tt, tbl[2].idx, rand_ent(), tbl[2].hdr);
        wait_accept("inflight_accept1");
        drive_req(tbl[3].mid, tbl[3].fl, tbl[3].tt, tbl[3].idx, rand_ent(), tbl[3].hdr);
        wait_accept("inflight_accept2");
        chk32("no_early_accept", exp_q.size(), 32'd4);
        req_valid = 1'b0;
        scramble();
        wait_done("inflight_timeout");
        chk32("inflight_cnt", tx_pkt_cnt, 32'd3);
        rdy_mode = 1'b0;

        // ENTRY_WIDTH = 256 build: header plus exactly one payload beat
        eee = {32{8'hee}};
        b_req_module_id = 8'h10; b_req_flags = 4'h0; b_req_table_type = 4'h3;
        b_req_index = 8'h04; b_req_entry = eee; b_req_valid = 1'b1;
        n = 0;
        while (b_req_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (b_req_ready !== 1'b1) fail("b_accept", "req_ready stuck 0", "accept");
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        b_req_entry = '0;
        chk32("b_hdr_tvalid", 32'(b_tvalid), 32'd1);
        chk32("b_hdr_tlast", 32'(b_tlast), 32'd0);
        chk32("b_hdr_tkeep", b_tkeep, 32'hffffffff);
        chk("b_hdr_tdata", b_tdata, {128'h04, 128'h30100000_0000f1f2_00000000_00000000});
        @(posedge clk);
        #1;
        chk32("b_pay_tvalid", 32'(b_tvalid), 32'd1);
        chk32("b_pay_tlast", 32'(b_tlast), 32'd1);
        chk("b_pay_tdata", b_tdata, eee);
        @(posedge clk);
        #1;
        chk32("b_end_tvalid", 32'(b_tvalid), 32'd0);
        chk32("b_end_tlast", 32'(b_tlast), 32'd0);
        chk32("b_end_ready", 32'(b_req_ready), 32'd1);
        chk32("b_cnt", b_cnt, 32'd1);
        chk("b_tuser", 256'(b_tuser), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
